// File: rtl/bht_predictor_if.sv
// bht_predictor_if: fetch lookup + EX update bundle for the BHT.
// master = IF/EX pipeline side, slave = predictor.
interface bht_predictor_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) ();
  logic [PC_W-1:0]  fetch_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_pred;
  logic             mispredict;
  logic             ready;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output fetch_pc,
    output upd_valid, upd_pc,
    output upd_taken, upd_target,
    output upd_pred,
    input  pred_taken, pred_target,
    input  mispredict, ready,
    input  mispred_cnt
  );

  modport slave (
    input  fetch_pc,
    input  upd_valid, upd_pc,
    input  upd_taken, upd_target,
    input  upd_pred,
    output pred_taken, pred_target,
    output mispredict, ready,
    output mispred_cnt
  );
endinterface

// File: rtl/bht_predictor.sv
// bht_predictor: direct-mapped BHT, 2-bit counters + targets.
// Ports: clk, rst (sync, active-high), bus (slave:
//   fetch lookup, EX update, mispredict/ready/mispred_cnt).
module bht_predictor #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  bht_predictor_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Table storage has no reset; the sweep clears it.
  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [1:0]       ctr_q   [DEPTH];
  logic [31:0]      tgt_q   [DEPTH];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic [1:0]       u_ctr;
  logic             run;

  logic             we, tgt_we;
  logic [IDX_W-1:0] w_idx;
  logic             w_valid;
  logic [TAG_W-1:0] w_tag;
  logic [1:0]       w_ctr;

  assign f_idx = bus.fetch_pc[IDX_W-1:0];
  assign f_tag = bus.fetch_pc[PC_W-1:IDX_W];
  assign u_idx = bus.upd_pc[IDX_W-1:0];
  assign u_tag = bus.upd_pc[PC_W-1:IDX_W];

  assign f_hit = valid_q[f_idx] &
                 (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] &
                 (tag_q[u_idx] == u_tag);
  assign u_ctr = ctr_q[u_idx];

  assign run   = (state_q == S_RUN);

  // Lookup reads pre-edge contents: no bypass.
  assign bus.ready       = run;
  assign bus.pred_taken  = run & f_hit &
                           ctr_q[f_idx][1];
  assign bus.pred_target = bus.pred_taken ?
                           tgt_q[f_idx] : 32'd0;
  assign bus.mispredict  = bus.upd_valid & run &
                           (bus.upd_pred !=
                            bus.upd_taken);
  assign bus.mispred_cnt = cnt_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    we        = 1'b0;
    tgt_we    = 1'b0;
    w_idx     = u_idx;
    w_valid   = 1'b1;
    w_tag     = u_tag;
    w_ctr     = u_ctr;
    if (!rst) begin
      unique case (state_q)
        S_CLEAR: begin
          we        = 1'b1;
          w_idx     = clr_idx_q;
          w_valid   = 1'b0;
          w_tag     = '0;
          w_ctr     = 2'b01;
          clr_idx_d = clr_idx_q + 1'b1;
          if (&clr_idx_q) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.upd_valid) begin
            unique case (1'b1)
              u_hit && bus.upd_taken: begin
                we     = 1'b1;
                tgt_we = 1'b1;
                if (u_ctr != 2'b11)
                  w_ctr = u_ctr + 2'b01;
              end
              u_hit && !bus.upd_taken: begin
                we = 1'b1;
                if (u_ctr != 2'b00)
                  w_ctr = u_ctr - 2'b01;
              end
              !u_hit && bus.upd_taken: begin
                we     = 1'b1;
                tgt_we = 1'b1;
                w_ctr  = 2'b10;
              end
              default: ;
            endcase
          end
          if (bus.mispredict && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      valid_q[w_idx] <= w_valid;
      tag_q[w_idx]   <= w_tag;
      ctr_q[w_idx]   <= w_ctr;
    end
    if (tgt_we)
      tgt_q[w_idx] <= bus.upd_target;
  end
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: directed vectors, queued expectations,
// negedge monitor compares against the predictor outputs.
module tb_bht_predictor;
  localparam int PC_W  = 10;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef struct {
    string       name;
    logic        ready;
    logic        taken;
    logic [31:0] tgt;
    logic        mp;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic done     = 1'b0;

  always #5 clk = ~clk;

  bht_predictor_if #(
    .PC_W (PC_W),
    .CNT_W(CNT_W)
  ) bus ();

  bht_predictor #(
    .PC_W (PC_W),
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic cmp(input string n,
                     input string f,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h",
               n, f, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "ready", 32'(bus.ready),
          32'(e.ready));
      cmp(e.name, "pred_taken",
          32'(bus.pred_taken), 32'(e.taken));
      cmp(e.name, "pred_target",
          bus.pred_target, e.tgt);
      cmp(e.name, "mispredict",
          32'(bus.mispredict), 32'(e.mp));
      cmp(e.name, "mispred_cnt",
          32'(bus.mispred_cnt), 32'(e.cnt));
    end
  end

  // One cycle of stimulus; chk=0 means no expectation.
  task automatic step(
    input string        n,
    input logic         chk,
    input logic         r,
    input logic [9:0]   fpc,
    input logic         uv,
    input logic [9:0]   upc,
    input logic         ut,
    input logic [31:0]  utgt,
    input logic         upred,
    input logic         er,
    input logic         ept,
    input logic [31:0]  etg,
    input logic         emp,
    input logic [3:0]   ecnt
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.fetch_pc   = fpc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utgt;
    bus.upd_pred   = upred;
    if (chk) begin
      e.name  = n;
      e.ready = er;
      e.taken = ept;
      e.tgt   = etg;
      e.mp    = emp;
      e.cnt   = ecnt;
      q.push_back(e);
    end
  endtask

  initial begin
    bus.fetch_pc   = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    bus.upd_pred   = 1'b0;

    step("rst0", 0, 1, 10'h015, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 0);
    step("rst1", 1, 1, 10'h015, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 0);
    // Sweep: 8 cycles not ready, updates dropped.
    for (int i = 0; i < 8; i++)
      step($sformatf("clr%0d", i), 1, 0,
           10'(i * 9), 1, 10'h015, 1, 32'h40, 0,
           0, 0, 0, 0, 0);

    step("alloc", 1, 0, 10'h015, 1, 10'h015, 1,
         32'h40, 0, 1, 0, 0, 1, 0);
    step("hit", 1, 0, 10'h015, 0, 0, 0, 0, 0,
         1, 1, 32'h40, 0, 1);
    step("nt1", 1, 0, 10'h015, 1, 10'h015, 0,
         32'h0, 1, 1, 1, 32'h40, 1, 1);
    step("nt2", 1, 0, 10'h015, 1, 10'h015, 0,
         32'h0, 0, 1, 0, 0, 0, 2);
    step("t1", 1, 0, 10'h015, 1, 10'h015, 1,
         32'h40, 0, 1, 0, 0, 1, 2);
    step("t2", 1, 0, 10'h015, 1, 10'h015, 1,
         32'h44, 0, 1, 0, 0, 1, 3);
    step("t3", 1, 0, 10'h015, 1, 10'h015, 1,
         32'h48, 1, 1, 1, 32'h44, 0, 4);
    step("t4", 1, 0, 10'h015, 1, 10'h015, 1,
         32'h48, 1, 1, 1, 32'h48, 0, 4);
    step("sat_nt", 1, 0, 10'h015, 1, 10'h015, 0,
         32'h0, 1, 1, 1, 32'h48, 1, 4);
    step("no_wrap", 1, 0, 10'h015, 0, 0, 0, 0, 0,
         1, 1, 32'h48, 0, 5);

    step("alias_miss", 1, 0, 10'h01D, 0, 0, 0, 0,
         0, 1, 0, 0, 0, 5);
    step("alias_upd", 1, 0, 10'h015, 1, 10'h01D, 1,
         32'h80, 0, 1, 1, 32'h48, 1, 5);
    step("evicted", 1, 0, 10'h015, 0, 0, 0, 0, 0,
         1, 0, 0, 0, 6);
    step("alias_hit", 1, 0, 10'h01D, 0, 0, 0, 0, 0,
         1, 1, 32'h80, 0, 6);

    step("rw_same", 1, 0, 10'h022, 1, 10'h022, 1,
         32'h123, 0, 1, 0, 0, 1, 6);
    step("rw_next", 1, 0, 10'h022, 0, 0, 0, 0, 0,
         1, 1, 32'h123, 0, 7);

    // Miss + not-taken mispredicts: no write, count only.
    for (int i = 0; i < 17; i++)
      step($sformatf("sat%0d", i), 1, 0, 10'h033,
           1, 10'h033, 0, 32'h0, 1, 1, 0, 0, 1,
           4'((7 + i > 15) ? 15 : 7 + i));
    step("cnt_top", 1, 0, 10'h022, 0, 0, 0, 0, 0,
         1, 1, 32'h123, 0, 15);

    step("rst_run", 0, 1, 10'h022, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step($sformatf("clr2_%0d", i), 1, 0,
           10'h022, 1, 10'h033, 0, 32'h0, 1,
           0, 0, 0, 0, 0);
    step("post_rst_a", 1, 0, 10'h022, 0, 0, 0, 0,
         0, 1, 0, 0, 0, 0);
    step("post_rst_b", 1, 0, 10'h01D, 0, 0, 0, 0,
         0, 1, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    done = 1'b1;
  end

  initial begin
    int budget;
    wait (done);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end
endmodule
